video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Parametrised raster timing generator; successor to the fixed 128x128 position counter.
//  Produces pixel coordinates plus blanking/sync/data-enable for any HxV mode with porches.
//  Optional clock-enable supports pixel rates below clk. Synchronous restart re-aligns frames.
//  Sits between the clock/reset block and the screen pattern/framebuffer readers.
// PARAMETERS
//  HACTIVE  128  visible pixels per line (>=1)
//  HFP      0    horizontal front porch, pixels (>=0)
//  HSYNC    0    hsync pulse width, pixels (>=0; 0 = hsync never asserted)
//  HBP      0    horizontal back porch, pixels (>=0)
//  VACTIVE  128  visible lines per frame (>=1)
//  VFP      0    vertical front porch, lines (>=0)
//  VSYNC    0    vsync width, lines (>=0; 0 = vsync never asserted)
//  VBP      0    vertical back porch, lines (>=0)
//  HS_POL   1    hsync active level (1 = active-high)
//  VS_POL   1    vsync active level
//  localparams: HTOTAL=HACTIVE+HFP+HSYNC+HBP, VTOTAL likewise; XW=max(1,$clog2(HTOTAL)), YW likewise
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous reset, active-low
//  ce           in   1   pixel enable; counters advance only on clk edges with ce=1
//  restart      in   1   synchronous frame restart
//  x            out  XW  horizontal count, 0..HTOTAL-1
//  y            out  YW  vertical count, 0..VTOTAL-1
//  de           out  1   1 when x<HACTIVE and y<VACTIVE
//  hsync        out  1   HS_POL when HACTIVE+HFP <= x < HACTIVE+HFP+HSYNC, else ~HS_POL
//  vsync        out  1   VS_POL when VACTIVE+VFP <= y < VACTIVE+VFP+VSYNC, else ~VS_POL
//  line_start   out  1   one-clk pulse: x just became 0
//  frame_start  out  1   one-clk pulse: x and y just became 0
// BEHAVIOUR
//  - Reset (rst_n=0, async): x=0, y=0, de=0, hsync=~HS_POL, vsync=~VS_POL, line_start=0, frame_start=0.
//  - All outputs registered. de/hsync/vsync always match the current (x,y) from the first
//    advance onward (decode the next position; zero added latency vs x,y).
//  - Exception: de stays 0 after reset until the first update; reset is not a frame start.
//  - Priority per edge: rst_n > restart > ce.
//  - restart=1: x=0, y=0, decode for (0,0), line_start=1, frame_start=1; ce ignored this cycle.
//  - ce=1, restart=0: x=HTOTAL-1 ? 0 : x+1; on x wrap, y=VTOTAL-1 ? 0 : y+1.
//    line_start=1 iff x wraps; frame_start=1 iff x and y both wrap.
//  - ce=0, restart=0: x,y,de,hsync,vsync hold; line_start=frame_start=0 (pulses exactly 1 clk
//    wide regardless of ce duty).
//  - vsync changes only when x wraps to 0 (line aligned).
//  - HSYNC=0/VSYNC=0: sync held inactive. Porch widths may be 0.
//  - Defaults reproduce the 128x128 free-running counter: de=1 always after first advance.
//  - Counter compares use exact equality with TOTAL-1; x,y never exceed TOTAL-1.
//  - Mid-frame rst_n assertion returns to the reset values immediately; counting resumes from (0,0).
// TESTING  (bench params: HACTIVE=4 HFP=1 HSYNC=2 HBP=1 -> HTOTAL=8; VACTIVE=3 VFP=1 VSYNC=1 VBP=1 -> VTOTAL=6)
//  1. Release reset, ce=1 for 48 clk -> x cycles 0..7; de=1 only for x<=3 and y<=2; hsync=1 at x=5,6;
//     vsync=1 for all of y=4; frame_start after 48 advances with (x,y)=(0,0).
//  2. ce 1-in-3 -> x,y advance every 3rd clk, outputs hold otherwise; line_start high 1 clk per line.
//  3. Hold at (7,5), ce=1 -> next (0,0), line_start=1, frame_start=1, vsync inactive.
//  4. restart at (5,2) with ce=1 -> next (0,0), de=1, both pulses=1; ce on that clk ignored.
//  5. rst_n low async at (3,1) between edges -> outputs at reset values before next edge;
//     after release, first ce gives (1,0) with no frame_start.
//  6. Defaults (128x128, no porches) -> x wraps 127->0, y increments; hsync=vsync=0; de=1 always.

Source files
------------

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel coordinates plus registered
// data-enable, sync and line/frame start pulses for any HxV mode with porches.
module video_timing_gen #(
  parameter int HACTIVE = 128,
  parameter int HFP     = 0,
  parameter int HSYNC   = 0,
  parameter int HBP     = 0,
  parameter int VACTIVE = 128,
  parameter int VFP     = 0,
  parameter int VSYNC   = 0,
  parameter int VBP     = 0,
  parameter bit HS_POL  = 1'b1,
  parameter bit VS_POL  = 1'b1,
  localparam int HTOTAL = HACTIVE + HFP + HSYNC + HBP,
  localparam int VTOTAL = VACTIVE + VFP + VSYNC + VBP,
  localparam int XW     = (HTOTAL > 1) ? $clog2(HTOTAL) : 1,
  localparam int YW     = (VTOTAL > 1) ? $clog2(VTOTAL) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          restart,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start
);

  localparam logic [XW-1:0] X_LAST   = XW'(HTOTAL - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(VTOTAL - 1);
  localparam int            HS_BEGIN = HACTIVE + HFP;
  localparam int            HS_END   = HACTIVE + HFP + HSYNC;
  localparam int            VS_BEGIN = VACTIVE + VFP;
  localparam int            VS_END   = VACTIVE + VFP + VSYNC;

  logic [XW-1:0] x_nx;
  logic [YW-1:0] y_nx;
  logic          adv;
  logic          ls_nx;
  logic          fs_nx;
  logic          de_nx;
  logic          hs_nx;
  logic          vs_nx;

  // Next position; restart outranks ce so a restart edge always lands on (0,0).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    x_nx  = x;
    y_nx  = y;
    adv   = 1'b0;
    ls_nx = 1'b0;
    fs_nx = 1'b0;
    if (restart) begin
      x_nx  = '0;
      y_nx  = '0;
      adv   = 1'b1;
      ls_nx = 1'b1;
      fs_nx = 1'b1;
    end else if (ce) begin
      adv = 1'b1;
      if (x == X_LAST) begin
        x_nx  = '0;
        ls_nx = 1'b1;
        if (y == Y_LAST) begin
          y_nx  = '0;
          fs_nx = 1'b1;
        end else begin
          y_nx = y + YW'(1);
        end
      end else begin
        x_nx = x + XW'(1);
      end
    end
  end

  // Decode the upcoming position so the registered flags line up with x,y.
  always_comb begin
    de_nx = (int'(x_nx) < HACTIVE) && (int'(y_nx) < VACTIVE);
    hs_nx = ((int'(x_nx) >= HS_BEGIN) && (int'(x_nx) < HS_END)) ? HS_POL : ~HS_POL;
    vs_nx = ((int'(y_nx) >= VS_BEGIN) && (int'(y_nx) < VS_END)) ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      x           <= x_nx;
      y           <= y_nx;
      line_start  <= ls_nx;
      frame_start <= fs_nx;
      if (adv) begin
        de    <= de_nx;
        hsync <= hs_nx;
        vsync <= vs_nx;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: a linear pixel-index model predicts each
// edge's outputs into a queue; monitors pop and compare on the falling edge.
module tb_video_timing_gen;

  typedef struct packed {
    int   x;
    int   y;
    logic de;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, ce, restart;
  logic [2:0] x;
  logic [2:0] y;
  logic       de, hsync, vsync, line_start, frame_start;

  logic       rst2_n, ce2, restart2;
  logic [6:0] x2;
  logic [6:0] y2;
  logic       de2, hsync2, vsync2, line_start2, frame_start2;

  int checks = 0;
  int errors = 0;
  exp_t q1[$];
  exp_t q2[$];

  // Model state for the small mode: linear pixel index within the 8x6 frame.
  int pos = 0;
  bit started = 0;
  bit done2 = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .HACTIVE(4), .HFP(1), .HSYNC(2), .HBP(1),
    .VACTIVE(3), .VFP(1), .VSYNC(1), .VBP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .restart(restart),
    .x(x), .y(y), .de(de), .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start)
  );

  video_timing_gen dut_def (
    .clk(clk), .rst_n(rst2_n), .ce(ce2), .restart(restart2),
    .x(x2), .y(y2), .de(de2), .hsync(hsync2), .vsync(vsync2),
    .line_start(line_start2), .frame_start(frame_start2)
  );

  function automatic exp_t model_out(int p, int ht, int ha, int hs0, int hs1,
                                     int va, int vs0, int vs1, bit st, bit ls, bit fs);
    exp_t e;
    e.x  = p % ht;
    e.y  = p / ht;
    e.de = st && (e.x < ha) && (e.y < va);
    e.hs = (e.x >= hs0) && (e.x < hs1);
    e.vs = (e.y >= vs0) && (e.y < vs1);
    e.ls = ls;
    e.fs = fs;
    return e;
  endfunction

  function automatic exp_t small_out(bit ls, bit fs);
    return model_out(pos, 8, 4, 5, 7, 3, 4, 5, started, ls, fs);
  endfunction

  task automatic check(input string name, input exp_t a, input exp_t e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s @%0t got x=%0d y=%0d de=%0b hs=%0b vs=%0b ls=%0b fs=%0b want x=%0d y=%0d de=%0b hs=%0b vs=%0b ls=%0b fs=%0b",
               name, $time, a.x, a.y, a.de, a.hs, a.vs, a.ls, a.fs,
               e.x, e.y, e.de, e.hs, e.vs, e.ls, e.fs);
    end
  endtask

  // Drive inputs for the next edge, then predict and enqueue that edge's result.
  task automatic step(input bit ce_v, input bit rs_v);
    bit ls, fs;
    ce = ce_v;
    restart = rs_v;
    @(posedge clk);
    #1;
    ls = 0;
    fs = 0;
    if (rs_v) begin
      pos = 0; started = 1; ls = 1; fs = 1;
    end else if (ce_v) begin
      pos = (pos + 1) % 48; started = 1;
      ls = (pos % 8) == 0;
      fs = pos == 0;
    end
    q1.push_back(small_out(ls, fs));
  endtask

  task automatic goto(input int target);
    for (int i = 0; i < 100 && pos != target; i++) step(1'b1, 1'b0);
  endtask

  // Assert reset between edges; the falling-edge monitor sees it before the next rising edge.
  task automatic async_reset();
    ce = 1'b0;
    restart = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    pos = 0;
    started = 0;
    q1.push_back(small_out(1'b0, 1'b0));
    @(posedge clk);
    #1;
    q1.push_back(small_out(1'b0, 1'b0));
    rst_n = 1'b1;
  endtask

  initial begin : monitor_small
    exp_t a, e;
    forever begin
      @(negedge clk);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        a = '{x: int'(x), y: int'(y), de: de, hs: hsync, vs: vsync,
              ls: line_start, fs: frame_start};
        check("mode8x6", a, e);
      end
    end
  end

  initial begin : monitor_default
    exp_t a, e;
    forever begin
      @(negedge clk);
      if (q2.size() > 0) begin
        e = q2.pop_front();
        a = '{x: int'(x2), y: int'(y2), de: de2, hs: hsync2, vs: vsync2,
              ls: line_start2, fs: frame_start2};
        check("mode128", a, e);
      end
    end
  end

  initial begin : drive_default
    int p2;
    bit st2;
    rst2_n = 1'b0;
    ce2 = 1'b0;
    restart2 = 1'b0;
    p2 = 0;
    st2 = 0;
    @(posedge clk);
    #1;
    q2.push_back(model_out(0, 128, 128, 128, 128, 128, 128, 128, 1'b0, 1'b0, 1'b0));
    rst2_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ce2 = 1'b1;
      @(posedge clk);
      #1;
      p2 = (p2 + 1) % 16384;
      st2 = 1;
      q2.push_back(model_out(p2, 128, 128, 128, 128, 128, 128, 128, st2,
                             (p2 % 128) == 0, p2 == 0));
    end
    ce2 = 1'b0;
    done2 = 1;
  end

  initial begin : drive_small
    rst_n = 1'b0;
    ce = 1'b0;
    restart = 1'b0;
    @(posedge clk);
    #1;
    q1.push_back(small_out(1'b0, 1'b0));
    @(posedge clk);
    #1;
    q1.push_back(small_out(1'b0, 1'b0));
    rst_n = 1'b1;

    // Full frame at ce=1, back to (0,0) with frame_start.
    repeat (48) step(1'b1, 1'b0);

    // ce one clock in three.
    repeat (10) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
    end

    // Hold on the last pixel, then wrap both counters.
    goto(47);
    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b0);

    // Restart at (5,2) while ce is also high.
    goto(21);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);

    // Randomised ce/restart mix.
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0);

    // Asynchronous reset at (3,1), then resume counting.
    goto(11);
    async_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    ce = 1'b0;

    for (int i = 0; i < 2000 && (!done2 || q1.size() > 0 || q2.size() > 0); i++)
      @(posedge clk);
    if (!done2 || q1.size() > 0 || q2.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d/%0d done=%0b required 0/0/1", q1.size(), q2.size(), done2);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
